// File: rtl/lmg_move_packer.sv
// rtl/lmg_move_packer.sv - drains the LMG move FIFO into the move-list RAM with a count header and zero terminator
// Optional feature macro: MOVE_PACK_TIMEOUT_EN (adds parameter TIMEOUT and output timeout for the LMG-done wait).
module lmg_move_packer #(
    parameter int SLOTS      = 8,
    parameter int MOVE_W     = 18,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 16,
    parameter int MAX_MOVES  = 255,
`ifdef MOVE_PACK_TIMEOUT_EN
    parameter int TIMEOUT    = 4096,
`endif
    localparam int CNT_W     = $clog2(MAX_MOVES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              move_count,
    output logic                          overflow,
    output logic                          lmg_reset,
    input  logic                          lmg_done,
    input  logic                          lmg_fifo_empty,
    output logic                          lmg_rden,
    input  logic [SLOTS*(MOVE_W+1)-1:0]   lmg_fifo_out,
    output logic                          ram_wren,
    output logic [ADDR_WIDTH-1:0]         ram_wraddr,
    output logic [DATA_WIDTH-1:0]         ram_wdata
`ifdef MOVE_PACK_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    localparam int SW     = MOVE_W + 1;
    localparam int WORD_W = SLOTS * SW;
    localparam int KW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [KW-1:0]         LAST_K = KW'(SLOTS - 1);
    localparam logic [CNT_W-1:0]      MAX_C  = CNT_W'(MAX_MOVES);
    localparam logic [ADDR_WIDTH-1:0] HDR_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] MOVE_A = ADDR_WIDTH'(BASE_ADDR + 1);

    generate
        if (longint'(BASE_ADDR) + 1 + longint'(MAX_MOVES) >= (longint'(1) << ADDR_WIDTH)) begin : g_addr_chk
            $error("terminator address BASE_ADDR+1+MAX_MOVES does not fit in ADDR_WIDTH");
        end
        if (DATA_WIDTH < SW || DATA_WIDTH <= CNT_W) begin : g_data_chk
            $error("DATA_WIDTH too narrow for a move slot or the count header");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE, S_LRST, S_WAITD, S_POP, S_CAP, S_SCAN, S_HDR, S_TERM, S_DONE
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_start_d;
    logic [WORD_W-1:0]       r_buf;
    logic [KW-1:0]           r_k;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;
    logic                    r_pop;
    logic                    r_busy, r_done, r_overflow, r_lmg_reset;
    logic [CNT_W-1:0]        r_move_count;
    logic                    r_wren;
    logic [ADDR_WIDTH-1:0]   r_wraddr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_start_edge, w_accept;
    logic [SW-1:0]           w_slot;
    logic                    w_slot_valid, w_any_valid, w_pop;
    logic                    w_wren;
    logic [ADDR_WIDTH-1:0]   w_wraddr;
    logic [DATA_WIDTH-1:0]   w_wdata;

`ifdef MOVE_PACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]         r_to_cnt;
    logic                    r_timeout;
    logic                    w_to_hit;
    assign timeout = r_timeout;
`endif

    assign w_start_edge = start & ~r_start_d;
    assign w_accept     = w_start_edge && (r_state == S_IDLE || r_state == S_DONE);
    assign w_slot       = r_buf[int'(r_k) * SW +: SW];
    assign w_slot_valid = ~w_slot[SW-1];

    always_comb begin
        w_any_valid = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (!r_buf[(k + 1) * SW - 1]) w_any_valid = 1'b1;
        end
    end

    // The pop decision is taken on the way into POP so lmg_rden is high during POP itself.
    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_wren   = 1'b0;
        w_wraddr = '0;
        w_wdata  = '0;
`ifdef MOVE_PACK_TIMEOUT_EN
        w_to_hit = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_DONE: if (w_start_edge) w_next = S_LRST;
            S_LRST:         w_next = S_WAITD;
            S_WAITD: begin
                if (lmg_done) begin
                    w_next = S_POP;
                    w_pop  = ~lmg_fifo_empty;
                end
`ifdef MOVE_PACK_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_next   = S_HDR;
                    w_to_hit = 1'b1;
                end
`endif
            end
            S_POP:          w_next = r_pop ? S_CAP : S_HDR;
            S_CAP:          w_next = S_SCAN;
            S_SCAN: begin
                if (w_slot_valid && r_count != MAX_C) begin
                    w_wren   = 1'b1;
                    w_wraddr = MOVE_A + ADDR_WIDTH'(r_count);
                    w_wdata  = DATA_WIDTH'(w_slot[MOVE_W-1:0]);
                end
                if (r_k == LAST_K) begin
                    if (w_any_valid) begin
                        w_next = S_POP;
                        w_pop  = ~lmg_fifo_empty;
                    end else begin
                        w_next = S_HDR;
                    end
                end
            end
            S_HDR: begin
                w_wren                 = 1'b1;
                w_wraddr               = HDR_A;
                w_wdata[CNT_W-1:0]     = r_count;
                w_wdata[DATA_WIDTH-1]  = r_ovf;
                w_next                 = S_TERM;
            end
            S_TERM: begin
                w_wren   = 1'b1;
                w_wraddr = MOVE_A + ADDR_WIDTH'(r_count);
                w_next   = S_DONE;
            end
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_start_d    <= 1'b0;
            r_buf        <= '0;
            r_k          <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_pop        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_lmg_reset  <= 1'b0;
            r_move_count <= '0;
            r_wren       <= 1'b0;
            r_wraddr     <= '0;
            r_wdata      <= '0;
`ifdef MOVE_PACK_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_start_d   <= start;
            r_pop       <= w_pop;
            r_lmg_reset <= (w_next == S_LRST);
            r_busy      <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done      <= (w_next == S_DONE);
            r_wren      <= w_wren;
            r_wraddr    <= w_wraddr;
            r_wdata     <= w_wdata;
            if (w_accept) begin
                r_count      <= '0;
                r_ovf        <= 1'b0;
                r_move_count <= '0;
                r_overflow   <= 1'b0;
`ifdef MOVE_PACK_TIMEOUT_EN
                r_timeout    <= 1'b0;
`endif
            end
            if (r_state == S_CAP) begin
                r_buf <= lmg_fifo_out;
                r_k   <= '0;
            end
            if (r_state == S_SCAN) begin
                r_k <= r_k + 1'b1;
                if (w_slot_valid) begin
                    if (r_count != MAX_C) r_count <= r_count + 1'b1;
                    else                  r_ovf   <= 1'b1;
                end
            end
            if (w_next == S_DONE) begin
                r_move_count <= r_count;
                r_overflow   <= r_ovf;
            end
`ifdef MOVE_PACK_TIMEOUT_EN
            r_to_cnt <= (r_state == S_WAITD) ? r_to_cnt + 1'b1 : '0;
            if (w_to_hit) r_timeout <= 1'b1;
`endif
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign move_count = r_move_count;
    assign overflow   = r_overflow;
    assign lmg_reset  = r_lmg_reset;
    assign lmg_rden   = r_pop;
    assign ram_wren   = r_wren;
    assign ram_wraddr = r_wraddr;
    assign ram_wdata  = r_wdata;

endmodule

// File: doc/lmg_move_packer.md
Name: lmg_move_packer

Overview:
Parametrised drain and compaction engine between the LMG move FIFO and the 32-bit move-list block RAM.
- On start, pulses LMG reset, waits for LMG done, then pops FIFO words of SLOTS packed move slots.
- Writes each valid move to consecutive RAM words, then a count header and a zero terminator.
- Successor to the fixed 8-slot readWord chain in the control block: generalised slot count, slot width, base address and move limit; adds FIFO-empty handling and overflow reporting.

Parameters:
SLOTS, 8, move slots per LMG FIFO word
MOVE_W, 18, move payload bits per slot; each slot is MOVE_W+1 bits with the invalid flag in its MSB (1 = invalid)
ADDR_WIDTH, 15, RAM word-address width
DATA_WIDTH, 32, RAM data width; must be at least MOVE_W+1
BASE_ADDR, 16, header address; moves start at BASE_ADDR+1
MAX_MOVES, 255, move-list capacity; CNT_W = clog2(MAX_MOVES+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  level; a rising edge (0 to 1 versus the previous cycle) in IDLE or DONE begins an operation
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE; held until the next accepted start or reset
move_count  out  CNT_W  moves written; valid while done
overflow  out  1  at least one valid move was dropped; valid while done
lmg_reset  out  1  one-cycle reset pulse to the LMG
lmg_done  in  1  LMG has finished generating moves
lmg_fifo_empty  in  1  LMG FIFO empty
lmg_rden  out  1  FIFO pop; read data is valid on lmg_fifo_out the cycle after the pop
lmg_fifo_out  in  SLOTS*(MOVE_W+1)  FIFO word; slot k occupies bits [(k+1)*(MOVE_W+1)-1 : k*(MOVE_W+1)]
ram_wren  out  1  RAM write enable
ram_wraddr  out  ADDR_WIDTH  RAM write address
ram_wdata  out  DATA_WIDTH  RAM write data

Behaviour:
- Reset: all outputs 0; state IDLE; count, slot index and flags cleared. Reset mid-operation aborts immediately; no further RAM writes.
- All outputs are registered.
- IDLE/DONE: a start rising edge at cycle t gives lmg_reset=1 at t+1 (state LRST), clears count/overflow and drops done. Start edges in any other state are ignored.
- LRST -> WAITD after 1 cycle.
- WAITD: wait for lmg_done=1, sampled no earlier than the cycle after LRST, then go to POP.
- POP:
  - lmg_fifo_empty=1: go to HDR with no pop.
  - Otherwise: lmg_rden=1 for exactly 1 cycle, then CAP.
- CAP: register lmg_fifo_out into the word buffer; set slot index k=0; go to SCAN.
- SCAN: one slot per cycle, k = 0 to SLOTS-1.
  - Slot valid and count < MAX_MOVES: ram_wren=1, ram_wraddr = BASE_ADDR+1+count, ram_wdata = zero-extended payload, count++.
  - Slot valid and count = MAX_MOVES: no write; overflow=1.
  - Slot invalid: no write; the cycle is still consumed.
- After k = SLOTS-1:
  - All SLOTS flags in the buffered word were invalid: go to HDR.
  - Otherwise: go to POP.
- HDR: write ram_wdata = {overflow, zeros, count} (overflow in bit DATA_WIDTH-1, count in the low CNT_W bits) at BASE_ADDR.
- TERM: write 0 at BASE_ADDR+1+count.
  - When count = MAX_MOVES, the terminator address is BASE_ADDR+1+MAX_MOVES. This must fit in ADDR_WIDTH; the implementation checks this at elaboration.
- TERM -> DONE. In DONE: done=1, move_count=count.
- At most one RAM write per cycle. Address arithmetic is ADDR_WIDTH wide modulo 2^ADDR_WIDTH; count saturates at MAX_MOVES.
- Per-word cost: POP(1) + CAP(1) + SCAN(SLOTS).

Optional Feature:
MOVE_PACK_TIMEOUT_EN
- Defined:
  - Adds parameter TIMEOUT (default 4096) and output timeout (1 bit, reset 0).
  - In WAITD, a counter runs from entry. If lmg_done is still low after TIMEOUT cycles, go to HDR with count 0 and set timeout=1; timeout is held with done.
  - An accepted start clears timeout.
- Undefined: WAITD waits indefinitely; no timeout port or parameter.

Test Plan:
- SLOTS=8. One word with slots 0,2,5 valid (payloads 0x00101, 0x00202, 0x00505), then an all-invalid word -> writes 0x101 @17, 0x202 @18, 0x505 @19; header 3 @16; 0 @20; done=1, move_count=3, overflow=0.
- lmg_done rises 10 cycles after lmg_reset; FIFO empty at the first POP -> lmg_rden never asserted; header 0 @16; terminator 0 @17; done=1.
- MAX_MOVES=4; three words with 8 valid moves each -> exactly 4 move writes @17..20; header 0x80000004 @16; terminator 0 @21; overflow=1.
- Reset asserted during SCAN at slot 3 -> no RAM writes from the next cycle on; all outputs 0; a new start pulse later completes a normal list.
- Start held high through DONE, then pulsed low and high again -> only one operation per rising edge; done drops the cycle after the second edge.
- With MOVE_PACK_TIMEOUT_EN and TIMEOUT=16; lmg_done held low -> HDR entered 16 cycles after WAITD entry; header 0 @16; timeout=1, done=1.
